// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors and the
// parity-bit function used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Parity bit a transmitter appends; narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [31:0] data, input logic [1:0] ptype);
        logic ones_odd;
        ones_odd = ^data;
        return (ptype == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset
// to RESET_VALUE so an idle-high line shows no edge when reset is released.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first data, optional parity, one stop bit.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [1:0]           parity_type,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CLOCK_CTR_WIDTH-1:0] HALF_BIT = CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CLOCK_CTR_WIDTH-1:0] FULL_BIT = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(DATA_BITS - 1);

    rx_state_t                state, state_next;
    logic [CLOCK_CTR_WIDTH-1:0] ctr, ctr_next;
    logic [IDX_W-1:0]         bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0]     shift, shift_next;
    logic                     wait_high, wait_high_next;
    logic                     deliver;
    logic                     line;

`ifdef UART_RX_PARITY_EN
    logic [1:0] par_type_q, par_type_next;
    logic       par_bad, par_bad_next;
`else
    logic [1:0] unused_parity_type;
    assign unused_parity_type = parity_type;
    assign parity_err = 1'b0;
`endif

    uart_sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (serial_in),
        .q   (line)
    );

    assign rx_busy = (state != RX_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            ctr        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            wait_high  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_type_q <= PAR_NONE;
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            ctr        <= ctr_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            wait_high  <= wait_high_next;
            rx_valid   <= deliver;
`ifdef UART_RX_PARITY_EN
            par_type_q <= par_type_next;
            par_bad    <= par_bad_next;
`endif
            if (deliver) begin
                rx_data   <= shift;
                frame_err <= ~line;
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
            end
        end
    end

    // After a stop bit sampled low, IDLE ignores the line until it has been high once (break handling).
    always_comb begin
        state_next     = state;
        ctr_next       = ctr;
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        wait_high_next = wait_high;
        deliver        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_type_next  = par_type_q;
        par_bad_next   = par_bad;
`endif
        case (state)
            RX_IDLE: begin
                ctr_next     = '0;
                bit_idx_next = '0;
                if (wait_high) begin
                    if (line) begin
                        wait_high_next = 1'b0;
                    end
                end else if (!line) begin
                    state_next = RX_START;
`ifdef UART_RX_PARITY_EN
                    par_type_next = (parity_type == 2'd3) ? PAR_NONE : parity_type;
                    par_bad_next  = 1'b0;
`endif
                end
            end
            RX_START: begin
                if (ctr == HALF_BIT) begin
                    ctr_next   = '0;
                    state_next = line ? RX_IDLE : RX_DATA;
                end else begin
                    ctr_next = ctr + CLOCK_CTR_WIDTH'(1);
                end
            end
            RX_DATA: begin
                if (ctr == FULL_BIT) begin
                    ctr_next                  = '0;
                    shift_next                = shift >> 1;
                    shift_next[DATA_BITS-1]   = line;
                    if (bit_idx == LAST_IDX) begin
                        bit_idx_next = '0;
                        state_next   = RX_STOP;
`ifdef UART_RX_PARITY_EN
                        if (par_type_q != PAR_NONE) begin
                            state_next = RX_PARITY;
                        end
`endif
                    end else begin
                        bit_idx_next = bit_idx + IDX_W'(1);
                    end
                end else begin
                    ctr_next = ctr + CLOCK_CTR_WIDTH'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (ctr == FULL_BIT) begin
                    ctr_next     = '0;
                    par_bad_next = (line != parity_bit(32'(shift), par_type_q));
                    state_next   = RX_STOP;
                end else begin
                    ctr_next = ctr + CLOCK_CTR_WIDTH'(1);
                end
            end
`endif
            RX_STOP: begin
                if (ctr == FULL_BIT) begin
                    ctr_next       = '0;
                    deliver        = 1'b1;
                    wait_high_next = ~line;
                    state_next     = RX_IDLE;
                end else begin
                    ctr_next = ctr + CLOCK_CTR_WIDTH'(1);
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model queues the expected
// word and error flags for every frame sent; a negedge monitor checks them.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b1;
    logic [1:0]    parity_type = 2'd0;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          rx_busy;

    uart_rx #(
        .CLOCKS_PER_BIT  (CPB),
        .DATA_BITS       (DB),
        .CLOCK_CTR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .parity_type (parity_type),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } frame_t;

    frame_t        exp_q[$];
    int            compared   = 0;
    int            mismatched = 0;
    logic [DB-1:0] last_data  = '0;
    logic          last_perr  = 1'b0;
    logic          last_ferr  = 1'b0;
    logic          prev_valid = 1'b0;
    logic          rst_q      = 1'b0;
    logic          started    = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Parity bit a correct transmitter sends: odd makes the total count of ones odd, even makes it even.
    function automatic logic model_parity(input logic [DB-1:0] d, input logic [1:0] ptype);
        int ones;
        ones = $countones(d);
        return (ptype == 2'd1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    endfunction

    always @(posedge clk) begin
        rst_q   <= rst;
        started <= 1'b1;
    end

    // Reset discards any frame in flight; otherwise a valid pulse delivers the oldest
    // queued frame and between pulses the outputs must hold the last delivery.
    always @(negedge clk) begin
        if (started) begin
            if (rst_q) begin
                exp_q.delete();
                last_data = '0;
                last_perr = 1'b0;
                last_ferr = 1'b0;
                check_output("reset_valid", 32'(rx_valid), 32'd0);
                check_output("reset_data", 32'(rx_data), 32'd0);
                check_output("reset_perr", 32'(parity_err), 32'd0);
                check_output("reset_ferr", 32'(frame_err), 32'd0);
                check_output("reset_busy", 32'(rx_busy), 32'd0);
            end else if (rx_valid) begin
                check_output("valid_one_cycle", 32'(prev_valid), 32'd0);
                check_output("busy_at_valid", 32'(rx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    check_output("spurious_valid", 32'(rx_valid), 32'd0);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    check_output("frame_data", 32'(rx_data), 32'(f.data));
                    check_output("frame_perr", 32'(parity_err), 32'(f.perr));
                    check_output("frame_ferr", 32'(frame_err), 32'(f.ferr));
                    last_data = f.data;
                    last_perr = f.perr;
                    last_ferr = f.ferr;
                end
            end else begin
                check_output("hold_data", 32'(rx_data), 32'(last_data));
                check_output("hold_perr", 32'(parity_err), 32'(last_perr));
                check_output("hold_ferr", 32'(frame_err), 32'(last_ferr));
            end
            prev_valid = rx_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_line(input logic v, input int cycles);
        serial_in = v;
        repeat (cycles) tick();
    endtask

    // Sends one frame; abort_bit >= 0 pulses reset in the middle of that data bit and stops.
    task automatic apply_stimulus(input logic [DB-1:0] data, input logic [1:0] ptype,
                                  input logic flip_par, input logic stop_val, input int abort_bit);
        frame_t f;
        logic   has_par;
        logic   pbit;
        has_par = PAR_EN && (ptype == 2'd1 || ptype == 2'd2);
        pbit    = model_parity(data, ptype) ^ flip_par;
        f.data  = data;
        f.perr  = has_par && flip_par;
        f.ferr  = ~stop_val;
        exp_q.push_back(f);
        parity_type = ptype;
        hold_line(1'b0, CPB);
        parity_type = 2'($urandom_range(0, 3));
        for (int i = 0; i < DB; i++) begin
            if (i == abort_bit) begin
                hold_line(data[i], CPB / 2);
                rst = 1'b1;
                tick();
                tick();
                rst = 1'b0;
                serial_in = 1'b1;
                return;
            end
            hold_line(data[i], CPB);
        end
        if (has_par) begin
            hold_line(pbit, CPB);
        end
        hold_line(stop_val, CPB);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * CPB) begin
            tick();
            n++;
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tick();
        repeat (3) tick();
        rst = 1'b0;
        check_output("init_data", 32'(rx_data), 32'd0);
        check_output("init_valid", 32'(rx_valid), 32'd0);
        check_output("init_busy", 32'(rx_busy), 32'd0);
        hold_line(1'b1, 2 * CPB);

        // Pin the model's parity rule against hand-computed bits.
        check_output("model_par_07_odd", 32'(model_parity(8'h07, 2'd1)), 32'd0);
        check_output("model_par_01_even", 32'(model_parity(8'h01, 2'd2)), 32'd1);
        check_output("model_par_fe_even", 32'(model_parity(8'hFE, 2'd2)), 32'd1);

        apply_stimulus(8'hA5, 2'd0, 1'b0, 1'b1, -1);
        wait_drain("drain_a5");
        check_output("lit_a5_data", 32'(rx_data), 32'h0000_00A5);
        check_output("lit_a5_ferr", 32'(frame_err), 32'd0);
        hold_line(1'b1, CPB);

        apply_stimulus(8'h07, 2'd1, 1'b0, 1'b1, -1);
        wait_drain("drain_07_good");
        check_output("lit_07_perr_good", 32'(parity_err), 32'd0);
        apply_stimulus(8'h07, 2'd1, 1'b1, 1'b1, -1);
        wait_drain("drain_07_bad");
        check_output("lit_07_data", 32'(rx_data), 32'h0000_0007);
`ifdef UART_RX_PARITY_EN
        check_output("lit_07_perr_bad", 32'(parity_err), 32'd1);
`else
        check_output("lit_07_perr_bad", 32'(parity_err), 32'd0);
`endif
        hold_line(1'b1, CPB);

        apply_stimulus(8'h3C, 2'd0, 1'b0, 1'b0, -1);
        hold_line(1'b1, CPB);
        wait_drain("drain_3c");
        check_output("lit_3c_data", 32'(rx_data), 32'h0000_003C);
        check_output("lit_3c_ferr", 32'(frame_err), 32'd1);

        // Short low glitch: receiver goes busy, rejects it, and stays silent.
        hold_line(1'b0, 4);
        serial_in = 1'b1;
        check_output("glitch_busy", 32'(rx_busy), 32'd1);
        hold_line(1'b1, 2 * CPB);
        check_output("glitch_idle", 32'(rx_busy), 32'd0);
        apply_stimulus(8'h55, 2'd0, 1'b0, 1'b1, -1);
        wait_drain("drain_55");

        apply_stimulus(8'h01, 2'd2, 1'b0, 1'b1, -1);
        apply_stimulus(8'hFE, 2'd2, 1'b0, 1'b1, -1);
        wait_drain("drain_b2b");
        check_output("lit_fe_data", 32'(rx_data), 32'h0000_00FE);
        hold_line(1'b1, CPB);

        apply_stimulus(8'hE7, 2'd0, 1'b0, 1'b1, 4);
        check_output("abort_busy", 32'(rx_busy), 32'd0);
        check_output("abort_data", 32'(rx_data), 32'd0);
        hold_line(1'b1, 12 * CPB);
        check_output("abort_no_frame", 32'(exp_q.size()), 32'd0);
        apply_stimulus(8'h81, 2'd0, 1'b0, 1'b1, -1);
        wait_drain("drain_81");
        check_output("lit_81_data", 32'(rx_data), 32'h0000_0081);

        // Break: line stays low through and past the stop bit; only one frame may appear.
        apply_stimulus(8'h00, 2'd0, 1'b0, 1'b0, -1);
        hold_line(1'b0, 3 * CPB);
        wait_drain("drain_break");
        hold_line(1'b1, 2 * CPB);
        apply_stimulus(8'h5A, 2'd0, 1'b0, 1'b1, -1);
        wait_drain("drain_after_break");

        for (int k = 0; k < 24; k++) begin
            logic [DB-1:0] d;
            logic [1:0]    pt;
            logic          flip;
            logic          stop;
            int            gap;
            d    = DB'($urandom);
            pt   = 2'($urandom_range(0, 3));
            flip = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            apply_stimulus(d, pt, flip, stop, -1);
            hold_line(1'b1, gap * CPB);
        end
        hold_line(1'b1, CPB);
        wait_drain("drain_random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 434: clocks per serial bit period.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-003 Parameter CLOCK_CTR_WIDTH, default 32: width of the bit-period counter.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 serial_in  input  1  asynchronous UART line, idle high.
REQ-007 parity_type  input  2  0 = none, 1 = odd, 2 = even, 3 = treated as none.
REQ-008 rx_data  output  DATA_BITS  last received word, registered.
REQ-009 rx_valid  output  1  one-clock pulse when a frame completes.
REQ-010 parity_err  output  1  parity mismatch flag; qualified by rx_valid.
REQ-011 frame_err  output  1  stop bit sampled low; qualified by rx_valid.
REQ-012 rx_busy  output  1  high in every state except IDLE.

Function
REQ-013 serial_in SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
- Unused encodings return to IDLE.
REQ-015 In IDLE, a synchronized low SHALL move the FSM to START, clear the counter, and latch parity_type (3 maps to 0).
REQ-016 START SHALL count to (CLOCKS_PER_BIT-1)/2 and sample the line.
- Low: counter clears, go to DATA.
- High: false start, return to IDLE with no rx_valid.
REQ-017 DATA SHALL sample once every CLOCKS_PER_BIT clocks (mid-bit) into a shift register, LSB first.
- After DATA_BITS samples, go to PARITY if latched type is nonzero, else go to STOP.
REQ-018 PARITY SHALL sample one bit CLOCKS_PER_BIT after the last data sample.
- Mismatch is set when XOR(data, bit) is 0 for odd parity or 1 for even parity.
REQ-019 STOP SHALL sample CLOCKS_PER_BIT after the previous sample.
- frame_err = ~sample.
- On the next clock, rx_data is updated and rx_valid pulses for exactly one cycle with parity_err and frame_err valid.
- The FSM returns to IDLE on that same clock.
REQ-020 rx_data SHALL be delivered even when an error flag is set.
- Error flags hold their value until the next rx_valid.
REQ-021 parity_type changes after latching SHALL NOT affect the frame in progress.
REQ-022 After the stop-bit mid-sample, the receiver SHALL accept a new start edge immediately, supporting back-to-back frames with a single stop bit.
REQ-023 A low line continuing through STOP (break condition) SHALL report frame_err.
- The FSM then re-arms only after the line has been seen high at least once in IDLE.

Reset
REQ-024 On rst high at a clock edge the following SHALL be forced:
- FSM to IDLE; counter and bit index to 0.
- rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, rx_busy = 0.
- Synchronizer flops to 1.
REQ-025 Reset mid-frame SHALL abort the frame with no rx_valid pulse; the next falling edge after reset starts a fresh frame.

Configuration
REQ-026 Macro UART_RX_PARITY_EN SHALL control parity support.
- Defined: PARITY state and checker are compiled in, as above.
- Undefined: PARITY state is absent; parity_type is ignored (port kept); parity_err is tied 0; DATA always proceeds to STOP.

Structure
REQ-027 Shared package uart_pkg SHALL hold:
- the rx state encoding;
- parity_type constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2;
- a parity-compute function shared by the transmitter and receiver.
REQ-028 The synchronizer SHALL be a separate sub-module uart_sync2 (parameterizable reset value, default 1); all other logic is in uart_rx.

Verification (CLOCKS_PER_BIT = 16, DATA_BITS = 8)
REQ-029 Frame 0xA5, no parity, stop = 1 -> one rx_valid pulse, rx_data = 0xA5, both error flags 0.
REQ-030 Frame 0x07, odd parity, parity bit = 0 -> rx_data = 0x07, parity_err = 0.
- Same frame with parity bit = 1 -> parity_err = 1.
REQ-031 Frame 0x3C, stop bit driven 0 -> rx_valid pulses with rx_data = 0x3C and frame_err = 1.
REQ-032 Line low for 4 clocks, then high -> no rx_valid; rx_busy drops back to 0.
- A following frame 0x55 is received correctly.
REQ-033 Frames 0x01 and 0xFE sent back-to-back with even parity, sourced by the team's transmitter at the same parameters -> two rx_valid pulses in order, no errors.
REQ-034 rst asserted during bit 4 of a frame -> no rx_valid and all outputs 0.
- A following frame 0x81 is received correctly.
